// File: rtl/phase_frame_ctrl.sv
// AXI4-Lite register block with one frame counter per acquisition phase; counter updates emit the
// phase index on AXI-Stream through an event FIFO, and a zero write clears all counters and pulses a downstream reset.
module phase_frame_ctrl #(
  parameter int NUM_PHASES   = 2,
  parameter int CTR_WIDTH    = 32,
  parameter int RESET_CYCLES = 16,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic        clk,
  input  logic        reset,
  output logic        external_resetn,
  input  logic [31:0] S_AXI_AWADDR,
  input  logic        S_AXI_AWVALID,
  input  logic [2:0]  S_AXI_AWPROT,
  output logic        S_AXI_AWREADY,
  input  logic [31:0] S_AXI_WDATA,
  input  logic [3:0]  S_AXI_WSTRB,
  input  logic        S_AXI_WVALID,
  output logic        S_AXI_WREADY,
  output logic [1:0]  S_AXI_BRESP,
  output logic        S_AXI_BVALID,
  input  logic        S_AXI_BREADY,
  input  logic [31:0] S_AXI_ARADDR,
  input  logic        S_AXI_ARVALID,
  input  logic [2:0]  S_AXI_ARPROT,
  output logic        S_AXI_ARREADY,
  output logic [31:0] S_AXI_RDATA,
  output logic [1:0]  S_AXI_RRESP,
  output logic        S_AXI_RVALID,
  input  logic        S_AXI_RREADY,
  output logic [7:0]  AXIS_OUT_TDATA,
  output logic        AXIS_OUT_TVALID,
  input  logic        AXIS_OUT_TREADY
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [1:0] OKAY = 2'b00, SLVERR = 2'b10, DECERR = 2'b11;
  localparam logic [4:0] NP5 = 5'(NUM_PHASES);
  localparam logic [AW-1:0] PTR_ONE = 1;
  localparam logic [AW:0] CNT_ONE = 1;
  localparam logic [AW:0] CNT_FULL = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {W_IDLE, W_RESP, W_RESETTING} wstate_t;
  typedef enum logic {R_IDLE, R_DATA} rstate_t;

  wstate_t wstate;
  rstate_t rstate;
  logic [CTR_WIDTH-1:0] ctr [NUM_PHASES];
  logic [7:0]  rst_cnt;
  logic        overflow;
  logic [31:0] drop_count;
  logic [7:0]  fifo_mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] fifo_cnt;

  logic wr_accept, fifo_full, pop, push_ok, w_push, w_zero, w_is_ctr, w_strb_ok, r_is_ctr;
  logic [4:0] w_idx, w_ph, r_idx, r_ph;
  logic [CTR_WIDTH-1:0] w_data, w_cur;
  logic [31:0] r_val;
  logic [1:0]  r_resp;
  logic unused_bits;

  assign unused_bits = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR, S_AXI_ARADDR, S_AXI_WDATA};

  assign wr_accept       = (wstate == W_IDLE) & S_AXI_AWVALID & S_AXI_WVALID;
  assign S_AXI_AWREADY   = wr_accept;
  assign S_AXI_WREADY    = wr_accept;
  assign S_AXI_ARREADY   = (rstate == R_IDLE);
  assign external_resetn = ~(reset | (rst_cnt != 8'd0));

  assign fifo_full       = (fifo_cnt == CNT_FULL);
  assign AXIS_OUT_TVALID = (fifo_cnt != '0);
  assign AXIS_OUT_TDATA  = AXIS_OUT_TVALID ? fifo_mem[rd_ptr] : 8'd0;
  assign pop             = AXIS_OUT_TVALID & AXIS_OUT_TREADY;

  always_comb begin
    w_idx     = S_AXI_AWADDR[6:2];
    w_ph      = w_idx - 5'd4;
    w_is_ctr  = (w_idx >= 5'd4) && (w_ph < NP5);
    w_strb_ok = (S_AXI_WSTRB == 4'hF);
    w_data    = S_AXI_WDATA[CTR_WIDTH-1:0];
    w_cur     = '0;
    for (int i = 0; i < NUM_PHASES; i++)
      if (w_ph == 5'(i)) w_cur = ctr[i];
    w_zero  = w_is_ctr && w_strb_ok && (w_data == '0);
    w_push  = wr_accept && w_is_ctr && w_strb_ok && (w_data != '0) && (w_data != w_cur);
    // A pop on the same edge frees the slot, so a full FIFO can still take the push
    push_ok = w_push && (!fifo_full || pop);
  end

  always_comb begin
    r_idx    = S_AXI_ARADDR[6:2];
    r_ph     = r_idx - 5'd4;
    r_is_ctr = (r_idx >= 5'd4) && (r_ph < NP5);
    r_val    = 32'd0;
    r_resp   = OKAY;
    case (r_idx)
      5'd0: r_val = 32'd2;
      5'd1: r_val = {16'd0, 8'(fifo_cnt), 6'd0, overflow, wstate == W_RESETTING};
      5'd2: r_val = drop_count;
      default: begin
        if (r_is_ctr) begin
          for (int i = 0; i < NUM_PHASES; i++)
            if (r_ph == 5'(i) && wstate != W_RESETTING) r_val = 32'(ctr[i]);
        end else begin
          r_resp = DECERR;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (push_ok) fifo_mem[wr_ptr] <= 8'(w_ph);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wstate       <= W_IDLE;
      rstate       <= R_IDLE;
      for (int i = 0; i < NUM_PHASES; i++) ctr[i] <= '0;
      rst_cnt      <= 8'(RESET_CYCLES);
      overflow     <= 1'b0;
      drop_count   <= 32'd0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      fifo_cnt     <= '0;
      S_AXI_BVALID <= 1'b0;
      S_AXI_BRESP  <= OKAY;
      S_AXI_RVALID <= 1'b0;
      S_AXI_RRESP  <= OKAY;
      S_AXI_RDATA  <= 32'd0;
    end else begin
      if (rst_cnt != 8'd0) rst_cnt <= rst_cnt - 8'd1;

      if (wr_accept && w_zero) begin
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        fifo_cnt <= '0;
      end else begin
        if (pop)     rd_ptr <= rd_ptr + PTR_ONE;
        if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
        case ({push_ok, pop})
          2'b10:   fifo_cnt <= fifo_cnt + CNT_ONE;
          2'b01:   fifo_cnt <= fifo_cnt - CNT_ONE;
          default: ;
        endcase
      end

      if (w_push && !push_ok) begin
        overflow <= 1'b1;
        if (drop_count != 32'hFFFF_FFFF) drop_count <= drop_count + 32'd1;
      end

      case (wstate)
        W_IDLE: if (wr_accept) begin
          wstate       <= W_RESP;
          S_AXI_BVALID <= 1'b1;
          S_AXI_BRESP  <= OKAY;
          if (w_idx == 5'd0 || w_idx == 5'd2) begin
            S_AXI_BRESP <= SLVERR;
          end else if (w_idx == 5'd1) begin
            if (S_AXI_WDATA[1]) begin
              overflow   <= 1'b0;
              drop_count <= 32'd0;
            end
          end else if (w_is_ctr) begin
            if (!w_strb_ok) begin
              S_AXI_BRESP <= SLVERR;
            end else if (w_zero) begin
              for (int i = 0; i < NUM_PHASES; i++) ctr[i] <= '0;
              rst_cnt      <= 8'(RESET_CYCLES);
              wstate       <= W_RESETTING;
              S_AXI_BVALID <= 1'b0;
            end else begin
              for (int i = 0; i < NUM_PHASES; i++)
                if (w_ph == 5'(i)) ctr[i] <= w_data;
            end
          end else begin
            S_AXI_BRESP <= DECERR;
          end
        end
        W_RESETTING: if (rst_cnt == 8'd0) begin
          wstate       <= W_RESP;
          S_AXI_BVALID <= 1'b1;
        end
        W_RESP: if (S_AXI_BREADY) begin
          wstate       <= W_IDLE;
          S_AXI_BVALID <= 1'b0;
        end
        default: wstate <= W_IDLE;
      endcase

      case (rstate)
        R_IDLE: if (S_AXI_ARVALID) begin
          rstate       <= R_DATA;
          S_AXI_RVALID <= 1'b1;
          S_AXI_RDATA  <= r_val;
          S_AXI_RRESP  <= r_resp;
        end
        R_DATA: if (S_AXI_RREADY) begin
          rstate       <= R_IDLE;
          S_AXI_RVALID <= 1'b0;
        end
        default: rstate <= R_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_phase_frame_ctrl.sv
// Self-checking bench for phase_frame_ctrl: register vector table, AXIS scoreboard, and
// hand-written overflow, flush/reset-pulse, hold and mid-transaction reset sequences.
module tb_phase_frame_ctrl;
  localparam int NP = 2, CW = 32, RC = 16, FD = 16;
  localparam logic [1:0] OKAY = 2'b00, SLVERR = 2'b10, DECERR = 2'b11;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        external_resetn;
  logic [31:0] S_AXI_AWADDR = '0;
  logic        S_AXI_AWVALID = 1'b0;
  logic [2:0]  S_AXI_AWPROT = '0;
  logic        S_AXI_AWREADY;
  logic [31:0] S_AXI_WDATA = '0;
  logic [3:0]  S_AXI_WSTRB = 4'hF;
  logic        S_AXI_WVALID = 1'b0;
  logic        S_AXI_WREADY;
  logic [1:0]  S_AXI_BRESP;
  logic        S_AXI_BVALID;
  logic        S_AXI_BREADY = 1'b0;
  logic [31:0] S_AXI_ARADDR = '0;
  logic        S_AXI_ARVALID = 1'b0;
  logic [2:0]  S_AXI_ARPROT = '0;
  logic        S_AXI_ARREADY;
  logic [31:0] S_AXI_RDATA;
  logic [1:0]  S_AXI_RRESP;
  logic        S_AXI_RVALID;
  logic        S_AXI_RREADY = 1'b0;
  logic [7:0]  AXIS_OUT_TDATA;
  logic        AXIS_OUT_TVALID;
  logic        AXIS_OUT_TREADY = 1'b0;

  always #5 clk = ~clk;

  phase_frame_ctrl #(.NUM_PHASES(NP), .CTR_WIDTH(CW), .RESET_CYCLES(RC), .FIFO_DEPTH(FD)) dut (
    .clk(clk), .reset(reset), .external_resetn(external_resetn),
    .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWPROT(S_AXI_AWPROT),
    .S_AXI_AWREADY(S_AXI_AWREADY), .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB),
    .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY), .S_AXI_BRESP(S_AXI_BRESP),
    .S_AXI_BVALID(S_AXI_BVALID), .S_AXI_BREADY(S_AXI_BREADY), .S_AXI_ARADDR(S_AXI_ARADDR),
    .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARPROT(S_AXI_ARPROT), .S_AXI_ARREADY(S_AXI_ARREADY),
    .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP), .S_AXI_RVALID(S_AXI_RVALID),
    .S_AXI_RREADY(S_AXI_RREADY), .AXIS_OUT_TDATA(AXIS_OUT_TDATA),
    .AXIS_OUT_TVALID(AXIS_OUT_TVALID), .AXIS_OUT_TREADY(AXIS_OUT_TREADY)
  );

  int tests = 0;
  int failed = 0;
  int beats = 0;
  logic [7:0] exp_q[$];

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    int          evt;
    logic [1:0]  resp;
    logic [31:0] rdata;
  } vec_t;
  vec_t vt[19];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    tests++;
    failed++;
    $display("FAIL %s: handshake did not complete within its cycle budget", name);
  endtask

  task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                           output logic [1:0] resp, output int cyc);
    int n;
    S_AXI_AWADDR = a; S_AXI_WDATA = d; S_AXI_WSTRB = s;
    S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1; S_AXI_BREADY = 1'b1;
    #1;
    n = 0;
    while (!S_AXI_AWREADY && n < 50) begin @(posedge clk); #1; n++; end
    if (n == 50) timeout_fail("aw_accept");
    @(posedge clk); #1;
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
    cyc = 0;
    while (!S_AXI_BVALID && cyc < 100) begin @(posedge clk); #1; cyc++; end
    if (cyc == 100) timeout_fail("bvalid_wait");
    resp = S_AXI_BRESP;
    @(posedge clk); #1;
    S_AXI_BREADY = 1'b0;
  endtask

  task automatic axi_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] resp);
    int n;
    S_AXI_ARADDR = a; S_AXI_ARVALID = 1'b1; S_AXI_RREADY = 1'b1;
    #1;
    n = 0;
    while (!S_AXI_ARREADY && n < 50) begin @(posedge clk); #1; n++; end
    if (n == 50) timeout_fail("ar_accept");
    @(posedge clk); #1;
    S_AXI_ARVALID = 1'b0;
    n = 0;
    while (!S_AXI_RVALID && n < 50) begin @(posedge clk); #1; n++; end
    if (n == 50) timeout_fail("rvalid_wait");
    d = S_AXI_RDATA;
    resp = S_AXI_RRESP;
    @(posedge clk); #1;
    S_AXI_RREADY = 1'b0;
  endtask

  // Stream scoreboard: a transfer is committed on the next rising edge when both are high at the falling edge
  always @(negedge clk) begin
    if (!reset && AXIS_OUT_TVALID && AXIS_OUT_TREADY) begin
      beats++;
      if (exp_q.size() == 0) begin
        tests++;
        failed++;
        $display("FAIL axis_unexpected_beat: got tdata %0d, expected no beat", AXIS_OUT_TDATA);
      end else begin
        check("axis_tdata", {56'd0, AXIS_OUT_TDATA}, {56'd0, exp_q.pop_front()});
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  resp;
    logic [31:0] rd, rd_stat, rd_c0, rd_c1;
    logic [1:0]  st_resp;
    int cyc, n, b_start, model_drops;
    logic stable;
    logic [2:0]  bsnap;
    logic [34:0] rsnap;

    vt[0]  = '{1'b0, 32'h00, 32'h0,        4'hF, -1, OKAY,   32'h2};
    vt[1]  = '{1'b0, 32'h04, 32'h0,        4'hF, -1, OKAY,   32'h0};
    vt[2]  = '{1'b0, 32'h08, 32'h0,        4'hF, -1, OKAY,   32'h0};
    vt[3]  = '{1'b0, 32'h10, 32'h0,        4'hF, -1, OKAY,   32'h0};
    vt[4]  = '{1'b1, 32'h14, 32'h5,        4'hF,  1, OKAY,   32'h0};
    vt[5]  = '{1'b0, 32'h14, 32'h0,        4'hF, -1, OKAY,   32'h5};
    vt[6]  = '{1'b1, 32'h14, 32'h5,        4'hF, -1, OKAY,   32'h0};
    vt[7]  = '{1'b1, 32'h10, 32'hDEADBEEF, 4'hF,  0, OKAY,   32'h0};
    vt[8]  = '{1'b1, 32'h10, 32'h7,        4'h3, -1, SLVERR, 32'h0};
    vt[9]  = '{1'b0, 32'h10, 32'h0,        4'hF, -1, OKAY,   32'hDEADBEEF};
    vt[10] = '{1'b0, 32'h7C, 32'h0,        4'hF, -1, DECERR, 32'h0};
    vt[11] = '{1'b1, 32'h00, 32'h1,        4'hF, -1, SLVERR, 32'h0};
    vt[12] = '{1'b1, 32'h08, 32'h1,        4'hF, -1, SLVERR, 32'h0};
    vt[13] = '{1'b1, 32'h18, 32'h1,        4'hF, -1, DECERR, 32'h0};
    vt[14] = '{1'b0, 32'h18, 32'h0,        4'hF, -1, DECERR, 32'h0};
    vt[15] = '{1'b0, 32'h0C, 32'h0,        4'hF, -1, DECERR, 32'h0};
    vt[16] = '{1'b1, 32'h94, 32'h9,        4'hF,  1, OKAY,   32'h0};
    vt[17] = '{1'b0, 32'h14, 32'h0,        4'hF, -1, OKAY,   32'h9};
    vt[18] = '{1'b0, 32'h08, 32'h0,        4'hF, -1, OKAY,   32'h0};

    // Reset values and power-on reset pulse length
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID, S_AXI_RVALID, AXIS_OUT_TVALID,
                            S_AXI_BRESP, S_AXI_RRESP, S_AXI_RDATA, AXIS_OUT_TDATA, external_resetn}, 64'd0);
    reset = 1'b0;
    n = 0;
    while (!external_resetn && n < 100) begin @(posedge clk); #1; n++; end
    check("por_resetn_low_cycles", n, RC);

    AXIS_OUT_TREADY = 1'b1;
    for (int i = 0; i < 19; i++) begin
      if (vt[i].wr) begin
        if (vt[i].evt >= 0) exp_q.push_back(8'(vt[i].evt));
        axi_write(vt[i].addr, vt[i].data, vt[i].strb, resp, cyc);
        check($sformatf("vec%0d_bresp", i), resp, vt[i].resp);
      end else begin
        axi_read(vt[i].addr, rd, resp);
        check($sformatf("vec%0d_rresp", i), resp, vt[i].resp);
        check($sformatf("vec%0d_rdata", i), rd, vt[i].rdata);
      end
    end
    repeat (5) @(posedge clk);
    #1;
    check("table_queue_drained", exp_q.size(), 0);
    check("table_beats", beats, 3);

    // Overflow: consumer stalled, one more event than the FIFO holds
    AXIS_OUT_TREADY = 1'b0;
    model_drops = 0;
    for (int v = 1; v <= FD + 1; v++) begin
      if (exp_q.size() < FD) exp_q.push_back(8'd0);
      else model_drops++;
      axi_write(32'h10, 32'(v), 4'hF, resp, cyc);
      check($sformatf("ovf_wr%0d_bresp", v), resp, OKAY);
    end
    axi_read(32'h04, rd, resp);
    check("ovf_status", rd, 32'h0000_1002);
    axi_read(32'h08, rd, resp);
    check("ovf_drop_count", rd, model_drops);

    // Full FIFO with a pop on the same edge still accepts the push
    b_start = beats;
    exp_q.push_back(8'd0);
    AXIS_OUT_TREADY = 1'b1;
    axi_write(32'h10, 32'd100, 4'hF, resp, cyc);
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin @(posedge clk); #1; n++; end
    check("full_pop_push_drained", exp_q.size(), 0);
    check("full_pop_push_beats", beats - b_start, FD + 1);
    axi_read(32'h08, rd, resp);
    check("full_pop_push_drop_count", rd, model_drops);

    axi_write(32'h04, 32'h2, 4'hF, resp, cyc);
    check("status_clear_bresp", resp, OKAY);
    axi_read(32'h04, rd, resp);
    check("status_after_clear", rd, 32'h0);
    axi_read(32'h08, rd, resp);
    check("drop_after_clear", rd, 32'h0);

    // Zero write with events queued: flush, reset pulse, delayed response
    AXIS_OUT_TREADY = 1'b0;
    for (int v = 11; v <= 13; v++) begin
      exp_q.push_back(8'd0);
      axi_write(32'h10, 32'(v), 4'hF, resp, cyc);
    end
    axi_read(32'h04, rd, resp);
    check("queued3_status", rd, 32'h0000_0300);
    S_AXI_AWADDR = 32'h10; S_AXI_WDATA = 32'h0; S_AXI_WSTRB = 4'hF;
    S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1; S_AXI_BREADY = 1'b1;
    #1;
    check("zero_wr_awready", S_AXI_AWREADY, 1);
    @(posedge clk); #1;
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
    exp_q.delete();
    check("flush_tvalid", AXIS_OUT_TVALID, 0);
    b_start = beats;
    fork
      begin
        n = 0;
        while (!external_resetn && n < 100) begin @(posedge clk); #1; n++; end
        check("zero_resetn_low_cycles", n, RC);
        check("zero_bvalid_during_pulse", S_AXI_BVALID, 0);
        @(posedge clk); #1;
        check("zero_bvalid_after_pulse", {S_AXI_BVALID, S_AXI_BRESP}, {1'b1, OKAY});
        @(posedge clk); #1;
        S_AXI_BREADY = 1'b0;
      end
      begin
        axi_read(32'h04, rd_stat, st_resp);
        axi_read(32'h10, rd_c0, resp);
        axi_read(32'h14, rd_c1, resp);
      end
    join
    check("busy_status", {st_resp, rd_stat}, {OKAY, 32'h1});
    check("zero_ctr0", rd_c0, 0);
    check("zero_ctr1", rd_c1, 0);
    AXIS_OUT_TREADY = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("flush_no_beats", beats - b_start, 0);

    // Response channels hold while the master stalls
    exp_q.push_back(8'd1);
    S_AXI_AWADDR = 32'h14; S_AXI_WDATA = 32'h55; S_AXI_WSTRB = 4'hF;
    S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1; S_AXI_BREADY = 1'b0;
    @(posedge clk); #1;
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
    bsnap = {S_AXI_BVALID, S_AXI_BRESP};
    stable = 1'b1;
    repeat (10) begin @(posedge clk); #1; if ({S_AXI_BVALID, S_AXI_BRESP} !== bsnap) stable = 1'b0; end
    check("bresp_hold", {stable, bsnap}, {1'b1, 1'b1, OKAY});
    S_AXI_BREADY = 1'b1;
    @(posedge clk); #1;
    S_AXI_BREADY = 1'b0;
    check("bvalid_release", S_AXI_BVALID, 0);
    S_AXI_ARADDR = 32'h14; S_AXI_ARVALID = 1'b1; S_AXI_RREADY = 1'b0;
    @(posedge clk); #1;
    S_AXI_ARVALID = 1'b0;
    rsnap = {S_AXI_RVALID, S_AXI_RRESP, S_AXI_RDATA};
    stable = 1'b1;
    repeat (10) begin @(posedge clk); #1; if ({S_AXI_RVALID, S_AXI_RRESP, S_AXI_RDATA} !== rsnap) stable = 1'b0; end
    check("rdata_hold", {stable, rsnap}, {1'b1, 1'b1, OKAY, 32'h55});
    S_AXI_RREADY = 1'b1;
    @(posedge clk); #1;
    S_AXI_RREADY = 1'b0;
    check("rvalid_release", S_AXI_RVALID, 0);

    // Reset in the middle of a pending read and a zero write
    S_AXI_ARADDR = 32'h14; S_AXI_ARVALID = 1'b1;
    @(posedge clk); #1;
    S_AXI_ARVALID = 1'b0;
    S_AXI_AWADDR = 32'h10; S_AXI_WDATA = 32'h0; S_AXI_WSTRB = 4'hF;
    S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1; S_AXI_BREADY = 1'b1;
    @(posedge clk); #1;
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("midreset_rvalid_pending", S_AXI_RVALID, 1);
    reset = 1'b1;
    exp_q.delete();
    #1;
    check("midreset_outputs", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID, S_AXI_RVALID, AXIS_OUT_TVALID,
                               S_AXI_BRESP, S_AXI_RRESP, S_AXI_RDATA, AXIS_OUT_TDATA, external_resetn}, 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    S_AXI_RREADY = 1'b1;
    stable = 1'b0;
    repeat (40) begin @(posedge clk); #1; if (S_AXI_BVALID || S_AXI_RVALID) stable = 1'b1; end
    check("midreset_no_response", stable, 0);
    S_AXI_RREADY = 1'b0;
    S_AXI_BREADY = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule

// File: doc/phase_frame_ctrl.md
# phase_frame_ctrl

Parametrised AXI4-Lite control block holding one frame counter per acquisition phase (NUM_PHASES of them). A non-zero write that changes a counter queues a phase-index event on an AXI-Stream output through an internal FIFO that honours TREADY; a zero write clears every counter, flushes the queue and drives a timed reset pulse to downstream logic. It sits between the host AXI4-Lite interconnect and the frame-sequencing datapath.

## Interface
Parameters:
- NUM_PHASES, 2, number of frame counters, 1..16
- CTR_WIDTH, 32, counter width, 1..32; upper register bits read 0, upper write bits ignored
- RESET_CYCLES, 16, length of the external reset pulse in clocks, 1..255
- FIFO_DEPTH, 16, event FIFO depth, power of 2, 2..64

Ports:
- clk  in  1  sole clock
- reset  in  1  asynchronous, active-high
- external_resetn  out  1  active-low reset to downstream modules
- S_AXI_AWADDR/AWVALID/AWPROT in 32/1/3, S_AXI_AWREADY out 1  write address
- S_AXI_WDATA/WSTRB/WVALID in 32/4/1, S_AXI_WREADY out 1  write data
- S_AXI_BRESP out 2, S_AXI_BVALID out 1, S_AXI_BREADY in 1  write response
- S_AXI_ARADDR/ARVALID/ARPROT in 32/1/3, S_AXI_ARREADY out 1  read address
- S_AXI_RDATA out 32, S_AXI_RRESP out 2, S_AXI_RVALID out 1, S_AXI_RREADY in 1  read data
- AXIS_OUT_TDATA  out  8  phase index of the updated counter
- AXIS_OUT_TVALID  out  1  event valid
- AXIS_OUT_TREADY  in  1  consumer ready

## Operation
- Register index = (ADDR & 7'h7F) >> 2. Map: 0 MODULE_REV (read 2); 1 STATUS (bit0 reset_busy, bit1 overflow sticky, bits[15:8] FIFO occupancy); 2 DROP_COUNT (saturating 32-bit count of dropped events); 4+i FRAME_CTR[i], i < NUM_PHASES.
- Write to STATUS with bit1=1: clears overflow and DROP_COUNT. Writes to MODULE_REV/DROP_COUNT: SLVERR, no effect. Unmapped index (read or write): DECERR, no effect.
- FRAME_CTR write with WSTRB != 4'hF: SLVERR, no effect.
- FRAME_CTR[i] write, data (masked to CTR_WIDTH) == 0: every counter cleared, FIFO flushed, reset counter loaded with RESET_CYCLES, write FSM enters RESETTING.
- Data != 0 and != FRAME_CTR[i]: counter updated; byte i pushed to FIFO. FIFO full with no pop that cycle: event dropped, overflow set, DROP_COUNT incremented (saturates at 0xFFFFFFFF). Full with simultaneous pop: push succeeds.
- Data == current value: OKAY, no event.
- Write FSM: IDLE -> (AWVALID & WVALID) -> RESP -> (BREADY) -> IDLE; IDLE -> zero write -> RESETTING -> (reset counter reaches 0) -> RESP.
- Read FSM: IDLE -> ARVALID -> RDATA -> (RREADY) -> IDLE. Reads allowed in any write state; during RESETTING counters read 0, reset_busy = 1.
- external_resetn = ~(reset | reset_counter != 0); counter decrements by 1 per clock when non-zero.

## Timing
- On reset: AWREADY, WREADY, BVALID, RVALID, AXIS_OUT_TVALID = 0; BRESP, RRESP, RDATA, TDATA = 0; counters, DROP_COUNT, overflow = 0; FIFO empty; reset counter loaded with RESET_CYCLES, so external_resetn is low during reset and for RESET_CYCLES clocks after release.
- AWREADY = WREADY = (write FSM IDLE) & AWVALID & WVALID, combinational; AW and W always accepted on the same edge. A lone AWVALID or WVALID is not accepted.
- Non-reset write accepted at edge T: register update and FIFO push at T; BVALID high from T+1 until BREADY; event visible on TVALID from T+1 if FIFO was empty.
- Zero write accepted at edge T: external_resetn low from T+1 for exactly RESET_CYCLES clocks; BVALID rises the cycle after external_resetn returns high.
- ARREADY = read FSM IDLE; RVALID and RDATA registered one clock after the AR handshake, held until RREADY.
- AXIS: TVALID/TDATA held stable until TREADY; back-to-back events sustain one transfer per clock. Flush drops TVALID the cycle after the zero write.
- Asserting reset mid-transaction aborts it: no BVALID/RVALID is issued for the in-flight transaction.

## Test plan
- Release reset -> external_resetn low exactly 16 clocks, then high; read index 0 -> 0x2 OKAY.
- Write FRAME_CTR[1]=5 with TREADY=1 -> BRESP OKAY, one beat TDATA=1; write 5 again -> OKAY, no beat.
- TREADY=0, 17 distinct non-zero writes to FRAME_CTR[0] (FIFO_DEPTH=16) -> STATUS occupancy 16, overflow=1, DROP_COUNT=1; TREADY=1 -> 16 beats of TDATA=0.
- With 3 events queued, write FRAME_CTR[0]=0 -> TVALID drops, all counters read 0, external_resetn low 16 clocks, BVALID only afterwards; read during pulse -> STATUS bit0=1.
- Write index 4 with WSTRB=4'h3 -> SLVERR, counter unchanged; read index 31 -> DECERR; write STATUS bit1=1 -> overflow and DROP_COUNT cleared.
- Hold BREADY/RREADY low 10 clocks -> BVALID/RVALID and data held stable; assert reset mid-write -> BVALID=0, all outputs at reset values.
